// File: rtl/disp_scan_if.sv
// Display scan bus: carries the enable, the digit-select/nibble loop to the upstream mux,
// and the anode/segment/tick/prescaler outputs of disp_scan_ctrl.
interface disp_scan_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 en;
    logic [1:0]           sel;
    logic [3:0]           digit_i;
    logic [3:0]           an;
    logic [6:0]           seg;
    logic                 tick;
    logic [DIV_WIDTH-1:0] cnt;

    // master = the scan controller, slave = the surrounding system (enable source + nibble mux)
    modport master (
        input  en, digit_i,
        output sel, an, seg, tick, cnt
    );

    modport slave (
        output en, digit_i,
        input  sel, an, seg, tick, cnt
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with hex decode.
// Optional leading-zero blanking is compiled in when DISP_SCAN_LZB_EN is defined.
module disp_scan_ctrl #(
    parameter int DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_scan_if.master bus
);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    digit_e               r_sel;
    digit_e               w_sel_next;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_tick;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 w_wrap;
    logic                 w_blank;
    logic [3:0]           w_an_next;
    logic [6:0]           w_seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign w_wrap = bus.en && (&r_cnt);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (bus.en) r_cnt <= r_cnt + DIV_WIDTH'(1);
            r_tick <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sel <= DIG3;
        else        r_sel <= w_sel_next;
    end

    // NOTE: defaults come first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        w_sel_next = r_sel;
        if (w_wrap) begin
            case (r_sel)
                DIG3:    w_sel_next = DIG2;
                DIG2:    w_sel_next = DIG1;
                DIG1:    w_sel_next = DIG0;
                default: w_sel_next = DIG3;
            endcase
        end
    end

`ifdef DISP_SCAN_LZB_EN
    logic r_lead;

    // Re-armed on entry to the most significant digit; the first nonzero digit disarms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_lead <= 1'b1;
        else if (w_wrap && (r_sel == DIG0))      r_lead <= 1'b1;
        else if (bus.en && (bus.digit_i != 4'h0)) r_lead <= 1'b0;
    end

    assign w_blank = r_lead && (r_sel != DIG0) && (bus.digit_i == 4'h0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = 7'h7F;
        if (bus.en) begin
            w_an_next = ~(4'b0001 << r_sel);
            if (!w_blank) w_seg_next = hex_to_seg(bus.digit_i);
        end
    end

    // Display registers follow the current select, so an/seg trail sel by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.sel  = r_sel;
    assign bus.cnt  = r_cnt;
    assign bus.tick = r_tick;
    assign bus.an   = r_an;
    assign bus.seg  = r_seg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed scoreboard bench for disp_scan_ctrl at DIV_WIDTH=2; expectations follow
// DISP_SCAN_LZB_EN so the same bench serves both builds.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;
    localparam int DW = 2;

    typedef struct {
        string      tag;
        bit         full;
        logic [1:0] sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digits [4];
    logic [6:0] hex_tab [16];
    logic [6:0] frame_seg [4];
    logic [6:0] zero_seg [4];
    logic [6:0] cur_tab [4];
    exp_t       sb [$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    disp_scan_if #(.DIV_WIDTH(DW)) bus ();

    disp_scan_ctrl #(.DIV_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Upstream 4:1 nibble mux
    always_comb bus.digit_i = digits[bus.sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit full, input logic [1:0] sel,
                        input logic [3:0] an, input logic [6:0] seg, input logic tick);
        exp_t e;
        e.tag = tag; e.full = full; e.sel = sel; e.an = an; e.seg = seg; e.tick = tick;
        sb.push_back(e);
    endtask

    task automatic clock_and_compare();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'(1));
        end else begin
            e = sb.pop_front();
            check({e.tag, " an"},  32'(bus.an),  32'(e.an));
            check({e.tag, " seg"}, 32'(bus.seg), 32'(e.seg));
            if (e.full) begin
                check({e.tag, " sel"},  32'(bus.sel),  32'(e.sel));
                check({e.tag, " tick"}, 32'(bus.tick), 32'(e.tick));
            end
        end
    endtask

    // Edge k counted from the first enabled edge after reset with cnt=0.
    task automatic run_edges(input string tag, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            int sel_b;
            int sel_a;
            logic [3:0] an_e;
            sel_b = (3 - (k - 1) / 4) & 3;
            sel_a = (3 - k / 4) & 3;
            an_e  = ~(4'b0001 << sel_b);
            push($sformatf("%s k=%0d", tag, k), 1'b1, 2'(sel_a), an_e, cur_tab[sel_b],
                 (k % 4) == 0);
            clock_and_compare();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " sel"},  32'(bus.sel),  32'(3));
        check({tag, " an"},   32'(bus.an),   32'(4'b1111));
        check({tag, " seg"},  32'(bus.seg),  32'(7'h7F));
        check({tag, " tick"}, 32'(bus.tick), 32'(0));
        check({tag, " cnt"},  32'(bus.cnt),  32'(0));
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef DISP_SCAN_LZB_EN
        frame_seg = '{7'h12, 7'h08, 7'h7F, 7'h7F};
        zero_seg  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
        frame_seg = '{7'h12, 7'h08, 7'h40, 7'h40};
        zero_seg  = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
        digits = '{4'h5, 4'hA, 4'h0, 4'h0};
        cur_tab = frame_seg;
        bus.en = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset("reset");

        // Main frame sequence, then park at sel=2, cnt=1
        @(negedge clk);
        bus.en = 1'b1;
        rst_n  = 1'b1;
        run_edges("scan", 1, 21);
        check("pre_hold cnt", 32'(bus.cnt), 32'(1));

        // Hold and blank for 10 cycles
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push($sformatf("hold %0d", i), 1'b1, 2'd2, 4'b1111, 7'h7F, 1'b0);
            clock_and_compare();
            check($sformatf("hold %0d cnt", i), 32'(bus.cnt), 32'(1));
        end

        // Resume: sel advances after exactly 3 enabled clocks, no extra tick
        bus.en = 1'b1;
        push("resume 1", 1'b1, 2'd2, 4'b1011, frame_seg[2], 1'b0);
        clock_and_compare();
        push("resume 2", 1'b1, 2'd2, 4'b1011, frame_seg[2], 1'b0);
        clock_and_compare();
        push("resume 3", 1'b1, 2'd1, 4'b1011, frame_seg[2], 1'b1);
        clock_and_compare();

        // Asynchronous reset between edges while tick is high
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_edges("post_reset", 1, 4);

        // All-zero digits from a fresh frame
        digits = '{4'h0, 4'h0, 4'h0, 4'h0};
        cur_tab = zero_seg;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_edges("zeros", 1, 16);

        // Decode sweep on digit 0
        v = 0;
        for (int c = 0; c < 200 && v < 16; c++) begin
            if (bus.sel == 2'd0) begin
                digits[0] = 4'(v);
                push($sformatf("sweep %0h", v), 1'b0, 2'd0, 4'b1110, hex_tab[v], 1'b0);
                clock_and_compare();
                v++;
            end else begin
                @(negedge clk);
            end
        end
        check("sweep_complete", 32'(v), 32'(16));
        check("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
